// File: rtl/note_pkg.sv
// Shared widths and FSM encoding for the note interface (sequencer and player).
package note_pkg;
    localparam int NOTE_W   = 6;
    localparam int LEN_W    = 5;
    localparam int INSTR_W  = 4;
    localparam int REMAIN_W = 6;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_PLAY = 2'd3;

    // Length field encodes duration minus one; widen first so 31 maps to 32.
    function automatic logic [REMAIN_W-1:0] len_to_ticks(input logic [LEN_W-1:0] len);
        return REMAIN_W'(len) + REMAIN_W'(1);
    endfunction
endpackage

// File: rtl/note_duration_counter.sv
// Tick down-counter holding the remaining duration of the current note.
module note_duration_counter
    import note_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [REMAIN_W-1:0] load_ticks,
    input  logic                dec,
    output logic [REMAIN_W-1:0] remain,
    output logic [REMAIN_W-1:0] remain_next,
    output logic                done
);
    always_comb begin
        remain_next = remain;
        if (load)
            remain_next = load_ticks;
        else if (dec && (remain != '0))
            remain_next = remain - REMAIN_W'(1);
    end

    // Terminal count: the tick that takes the counter from 1 to 0.
    assign done = dec && !load && (remain == REMAIN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            remain <= '0;
        else
            remain <= remain_next;
    end
endmodule

// File: rtl/note_player.sv
// Per-channel note consumer: fetches notes from the sequencer and gates the voice.
//   state   | meaning
//   IDLE    | stopped, waiting for i_enable
//   REQ     | o_note_stb high for this single cycle
//   WAIT    | waiting for i_note_valid (abort if i_enable drops)
//   PLAY    | holding the note, counting tempo ticks down
module note_player
    import note_pkg::*;
#(
    parameter int RELEASE_TICKS = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_tick,
    output logic               o_note_stb,
    input  logic               i_note_valid,
    input  logic [NOTE_W-1:0]  i_note,
    input  logic [LEN_W-1:0]   i_note_len,
    input  logic [INSTR_W-1:0] i_instrument,
    output logic [NOTE_W-1:0]  o_voice_note,
    output logic [INSTR_W-1:0] o_voice_instrument,
    output logic               o_gate,
    output logic               o_note_on,
    output logic               o_busy
);
    localparam logic [REMAIN_W-1:0] REL = REMAIN_W'(RELEASE_TICKS);

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic                load;
    logic                dec;
    logic                done;
    logic [REMAIN_W-1:0] remain;
    logic [REMAIN_W-1:0] remain_next;
    logic [NOTE_W-1:0]   note_next;

    assign load = (state == ST_WAIT) && i_enable && i_note_valid;
    assign dec  = (state == ST_PLAY) && i_tick && (remain != '0);

    note_duration_counter u_counter (
        .clk         (i_clk),
        .rst         (i_rst),
        .load        (load),
        .load_ticks  (len_to_ticks(i_note_len)),
        .dec         (dec),
        .remain      (remain),
        .remain_next (remain_next),
        .done        (done)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (i_enable) state_next = ST_REQ;
            ST_REQ:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (!i_enable)
                    state_next = ST_IDLE;
                else if (i_note_valid)
                    state_next = ST_PLAY;
            end
            ST_PLAY: if (done) state_next = i_enable ? ST_REQ : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign note_next = load ? i_note : o_voice_note;

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state              <= ST_IDLE;
            o_note_stb         <= 1'b0;
            o_voice_note       <= '0;
            o_voice_instrument <= '0;
            o_gate             <= 1'b0;
            o_note_on          <= 1'b0;
            o_busy             <= 1'b0;
        end else begin
            state      <= state_next;
            o_note_stb <= (state_next == ST_REQ);
            o_busy     <= (state_next != ST_IDLE);
            o_note_on  <= load && (i_note != REST_NOTE);
            o_gate     <= (state_next == ST_PLAY) && (note_next != REST_NOTE)
                          && (remain_next > REL);
            if (load) begin
                o_voice_note       <= i_note;
                o_voice_instrument <= i_instrument;
            end
        end
    end
endmodule

// File: tb/tb_note_player.sv
// Directed plus randomized bench for note_player; two instances differ only in RELEASE_TICKS.
module tb_note_player;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_note_valid = 1'b0;
    logic [5:0] i_note = '0;
    logic [4:0] i_note_len = '0;
    logic [3:0] i_instrument = '0;

    logic       a_stb, a_gate, a_note_on, a_busy;
    logic [5:0] a_voice;
    logic [3:0] a_instr;
    logic       b_stb, b_gate, b_note_on, b_busy;
    logic [5:0] b_voice;
    logic [3:0] b_instr;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_voice = '0;
    logic [3:0] exp_instr = '0;

    always #5 i_clk = ~i_clk;

    note_player #(.RELEASE_TICKS(1)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_tick(i_tick),
        .o_note_stb(a_stb), .i_note_valid(i_note_valid), .i_note(i_note),
        .i_note_len(i_note_len), .i_instrument(i_instrument),
        .o_voice_note(a_voice), .o_voice_instrument(a_instr),
        .o_gate(a_gate), .o_note_on(a_note_on), .o_busy(a_busy)
    );

    note_player #(.RELEASE_TICKS(0)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_tick(i_tick),
        .o_note_stb(b_stb), .i_note_valid(i_note_valid), .i_note(i_note),
        .i_note_len(i_note_len), .i_instrument(i_instrument),
        .o_voice_note(b_voice), .o_voice_instrument(b_instr),
        .o_gate(b_gate), .o_note_on(b_note_on), .o_busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    // Gate is on while the note is not a rest and more ticks remain than the release gap.
    function automatic bit exp_gate(input logic [5:0] note, input int ticks_left, input int rel);
        return (note != 6'd0) && (ticks_left > rel);
    endfunction

    task automatic wait_stb(input string tag, output int n);
        n = 0;
        while (a_stb !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        check(tag, 32'(a_stb), 32'd1);
    endtask

    task automatic check_play(input logic [5:0] note, input int left, input bit first);
        check("gate_rel1", 32'(a_gate), 32'(exp_gate(note, left, 1)));
        check("gate_rel0", 32'(b_gate), 32'(exp_gate(note, left, 0)));
        check("stb_in_play", 32'(a_stb), 32'd0);
        check("busy_in_play", 32'(a_busy), 32'd1);
        check("voice_hold", 32'(a_voice), 32'(exp_voice));
        if (!first) check("note_on_once", 32'(a_note_on), 32'd0);
    endtask

    // Entered with the strobe visible; leaves one cycle after the final counted tick.
    task automatic do_note(input logic [5:0] note, input logic [4:0] len, input logic [3:0] instr,
                           input int delay, input int gap_max, input bit tick_on_valid,
                           input int drop_at);
        int  len1;
        int  left;
        int  gap;
        bit  first;
        bit  en;
        len1 = int'(len) + 1;
        check("stb_start", 32'(a_stb), 32'd1);
        check("stb_start_b", 32'(b_stb), 32'd1);
        i_tick = 1'($urandom_range(0, 1));
        step;
        i_tick = 1'b0;
        check("stb_single", 32'(a_stb), 32'd0);
        check("busy_wait", 32'(a_busy), 32'd1);
        for (int d = 0; d < delay; d++) begin
            i_tick = 1'($urandom_range(0, 1));
            step;
            i_tick = 1'b0;
            check("stb_wait", 32'(a_stb), 32'd0);
        end
        i_note_valid = 1'b1;
        i_note = note;
        i_note_len = len;
        i_instrument = instr;
        i_tick = tick_on_valid;
        step;
        i_note_valid = 1'b0;
        i_tick = 1'b0;
        i_note = 6'($urandom);
        i_note_len = 5'($urandom);
        i_instrument = 4'($urandom);
        exp_voice = note;
        exp_instr = instr;
        check("latch_note", 32'(a_voice), 32'(note));
        check("latch_instr", 32'(a_instr), 32'(instr));
        check("latch_note_b", 32'(b_voice), 32'(note));
        check("note_on", 32'(a_note_on), 32'(note != 6'd0));
        first = 1'b1;
        for (int k = 1; k <= len1; k++) begin
            left = len1 - k + 1;
            gap = int'($urandom_range(0, gap_max));
            if (drop_at == k) i_enable = 1'b0;
            for (int g = 0; g < gap; g++) begin
                check_play(note, left, first);
                step;
                first = 1'b0;
            end
            check_play(note, left, first);
            i_tick = 1'b1;
            step;
            i_tick = 1'b0;
            first = 1'b0;
        end
        en = i_enable;
        check("gate_end_rel1", 32'(a_gate), 32'd0);
        check("gate_end_rel0", 32'(b_gate), 32'd0);
        check("next_stb", 32'(a_stb), 32'(en));
        check("next_stb_b", 32'(b_stb), 32'(en));
        check("busy_end", 32'(a_busy), 32'(en));
        check("instr_hold", 32'(a_instr), 32'(exp_instr));
    endtask

    initial begin
        int n;
        logic [5:0] rn;
        #1 i_rst = 1'b1;
        #2;
        check("rst_stb", 32'(a_stb), 32'd0);
        check("rst_gate", 32'(a_gate), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_voice", 32'(a_voice), 32'd0);
        check("rst_instr", 32'(a_instr), 32'd0);
        check("rst_note_on", 32'(a_note_on), 32'd0);
        step;
        #2 i_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step;
            check("idle_no_stb", 32'(a_stb), 32'd0);
            check("idle_busy", 32'(a_busy), 32'd0);
        end
        i_enable = 1'b1;
        step;
        check("first_stb", 32'(a_stb), 32'd1);

        // Basic note, rest, short note, tick/valid collision, maximum length
        do_note(6'd12, 5'd3, 4'd2, 0, 0, 1'b0, 0);
        do_note(6'd0, 5'd2, 4'd7, 1, 2, 1'b0, 0);
        do_note(6'd5, 5'd0, 4'd3, 0, 1, 1'b0, 0);
        do_note(6'd7, 5'd2, 4'd1, 1, 1, 1'b1, 0);
        do_note(6'd20, 5'd31, 4'd15, 0, 0, 1'b0, 0);

        for (int r = 0; r < 10; r++) begin
            rn = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            do_note(rn, 5'($urandom_range(0, 6)), 4'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0);
        end

        // Enable drops mid-note: finish the note, then stay idle
        do_note(6'd9, 5'd3, 4'd4, 0, 1, 1'b0, 2);
        for (int c = 0; c < 4; c++) begin
            step;
            check("drop_no_stb", 32'(a_stb), 32'd0);
            check("drop_idle", 32'(a_busy), 32'd0);
        end

        // Enable drops in WAIT: request abandoned, late valid ignored
        i_enable = 1'b1;
        step;
        check("reenable_stb", 32'(a_stb), 32'd1);
        step;
        i_enable = 1'b0;
        step;
        check("abort_busy", 32'(a_busy), 32'd0);
        i_note_valid = 1'b1;
        i_note = 6'd33;
        i_note_len = 5'd4;
        i_instrument = 4'd11;
        step;
        i_note_valid = 1'b0;
        check("late_valid_voice", 32'(a_voice), 32'(exp_voice));
        check("late_valid_instr", 32'(a_instr), 32'(exp_instr));
        check("late_valid_note_on", 32'(a_note_on), 32'd0);
        check("late_valid_busy", 32'(a_busy), 32'd0);
        step;
        check("late_valid_stb", 32'(a_stb), 32'd0);

        // Asynchronous reset while the gate is high
        i_enable = 1'b1;
        wait_stb("stb_pre_rst", n);
        step;
        i_note_valid = 1'b1;
        i_note = 6'd40;
        i_note_len = 5'd6;
        i_instrument = 4'd9;
        step;
        i_note_valid = 1'b0;
        i_tick = 1'b1;
        step;
        i_tick = 1'b0;
        check("gate_before_rst", 32'(a_gate), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        check("async_gate", 32'(a_gate), 32'd0);
        check("async_gate_b", 32'(b_gate), 32'd0);
        check("async_voice", 32'(a_voice), 32'd0);
        check("async_instr", 32'(a_instr), 32'd0);
        check("async_busy", 32'(a_busy), 32'd0);
        check("async_stb", 32'(a_stb), 32'd0);
        exp_voice = '0;
        exp_instr = '0;
        step;
        #2 i_rst = 1'b0;
        wait_stb("stb_after_rst", n);
        check("stb_after_rst_latency", 32'(n), 32'd1);
        do_note(6'd3, 5'd1, 4'd5, 2, 1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
